// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with per-slot blanking and a frame-synchronous commit.
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN (suppresses leading-zero digits).
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [3:0] digit_out,
    output logic [3:0] an,
    output logic       frame_start
);
    localparam int unsigned   CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      sel, sel_nxt;
    logic            commit;
    logic [3:0][3:0] shadow, shadow_nxt;
    logic [3:0][3:0] active, active_nxt;
    logic [3:0]      an_nxt, digit_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
            cnt   <= '0;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        commit    = 1'b0;
        if (!en) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            sel_nxt   = '0;
        end else begin
            case (state)
                BLANK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == BLANK_LAST)
                        state_nxt = SHOW;
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        sel_nxt   = sel + 1'b1;
                        state_nxt = BLANK;
                        commit    = (sel == 2'd3);
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = BLANK;
            endcase
        end
    end

    // A write landing on the commit edge is merged so it appears in the new frame.
    always_comb begin
        shadow_nxt = shadow;
        if (wr_en)
            shadow_nxt[wr_addr] = wr_data;
        active_nxt = commit ? shadow_nxt : active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            shadow <= shadow_nxt;
            active <= active_nxt;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic lead_zero;

    always_comb begin
        lead_zero = (sel_nxt != 2'd0);
        for (int unsigned i = 0; i < 4; i++) begin
            if (i >= 32'(sel_nxt) && active_nxt[i] != 4'd0)
                lead_zero = 1'b0;
        end
    end
`endif

    // Outputs are decoded from next-state values and registered, so they change with the state.
    always_comb begin
        an_nxt    = 4'b1111;
        digit_nxt = 4'hF;
        if (state_nxt == SHOW) begin
            an_nxt    = ~(4'b0001 << sel_nxt);
            digit_nxt = active_nxt[sel_nxt];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (lead_zero) begin
                an_nxt    = 4'b1111;
                digit_nxt = 4'hF;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= 4'b1111;
            digit_out   <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            digit_out   <= digit_nxt;
            frame_start <= commit;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model predicts each cycle's outputs.
// Honours SEG_LEADING_ZERO_BLANK_EN in its reference model.
module tb_seg_scan_ctrl;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic [3:0] digit_out;
    logic [3:0] an;
    logic       frame_start;

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .digit_out(digit_out), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] dig;
        logic       fs;
    } exp_t;

    exp_t       q[$];
    int         vectors = 0;
    int         errors  = 0;
    int         pos     = 0;
    logic [3:0] m_shadow[4];
    logic [3:0] m_active[4];

    // Display content follows purely from the position within the frame.
    function automatic exp_t predict(input int p, input bit fs);
        exp_t e;
        int   s;
        bit   dark;
        s     = p / DIV;
        dark  = 1'b0;
        e.fs  = fs;
        e.an  = 4'hF;
        e.dig = 4'hF;
        if ((p % DIV) >= BLK) begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (s != 0) begin
                dark = 1'b1;
                for (int k = s; k < 4; k++)
                    if (m_active[k] != 4'd0) dark = 1'b0;
            end
`endif
            if (!dark) begin
                e.an  = 4'hF ^ (4'h1 << s);
                e.dig = m_active[s];
            end
        end
        return e;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 4'd0;
            m_active[i] = 4'd0;
        end
        forever begin
            bit fs;
            @(posedge clk);
            fs = 1'b0;
            if (!rst_n) begin
                pos = 0;
                for (int i = 0; i < 4; i++) begin
                    m_shadow[i] = 4'd0;
                    m_active[i] = 4'd0;
                end
            end else begin
                if (en) begin
                    if (pos == FRAME - 1) begin
                        for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
                        if (wr_en) m_active[wr_addr] = wr_data;
                        fs  = 1'b1;
                        pos = 0;
                    end else begin
                        pos = pos + 1;
                    end
                end else begin
                    pos = 0;
                end
                if (wr_en) m_shadow[wr_addr] = wr_data;
            end
            q.push_back(predict(pos, fs));
        end
    end

    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                vectors++;
                if (an !== e.an || digit_out !== e.dig || frame_start !== e.fs) begin
                    errors++;
                    $display("FAIL scan_cycle t=%0t: got an=%b digit=%h fs=%b, expected an=%b digit=%h fs=%b",
                             $time, an, digit_out, frame_start, e.an, e.dig, e.fs);
                end
            end else if (!rst_n) begin
                vectors++;
                if (an !== 4'b1111 || digit_out !== 4'hF || frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset t=%0t: got an=%b digit=%h fs=%b, expected an=1111 digit=f fs=0",
                             $time, an, digit_out, frame_start);
                end
            end
        end
    end

    // Inputs are set just after a falling edge, then held until the next falling edge.
    task automatic step(input bit e, input bit w, input logic [1:0] a, input logic [3:0] d);
        en = e; wr_en = w; wr_addr = a; wr_data = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 4'd0);
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (pos != target && guard < 2 * FRAME) begin
            step(1'b1, 1'b0, 2'd0, 4'd0);
            guard++;
        end
    endtask

    task automatic pulse_reset(input int low_cycles);
        #2 rst_n = 1'b0;
        for (int i = 0; i < low_cycles; i++) step(1'b1, 1'b0, 2'd0, 4'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b0, 1'b0, 2'd0, 4'd0);
        rst_n = 1'b1;
        idle(2 * FRAME + 6);

        run_to(DIV + 3);
        step(1'b1, 1'b1, 2'd0, 4'd5);
        step(1'b1, 1'b1, 2'd3, 4'd9);
        idle(FRAME + DIV);

        run_to(FRAME - 1);
        step(1'b1, 1'b1, 2'd1, 4'd7);
        step(1'b1, 1'b1, 2'd1, 4'd4);
        idle(2 * FRAME);

        run_to(2 * DIV + BLK + 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 4'd0);
        idle(FRAME + 4);

        step(1'b1, 1'b1, 2'd2, 4'd6);
        run_to(DIV + 4);
        pulse_reset(2);
        idle(FRAME + 4);

        step(1'b1, 1'b1, 2'd3, 4'd0);
        step(1'b1, 1'b1, 2'd2, 4'd0);
        step(1'b1, 1'b1, 2'd1, 4'd3);
        step(1'b1, 1'b1, 2'd0, 4'd0);
        idle(2 * FRAME);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'(i), 4'd0);
        idle(2 * FRAME);
        step(1'b1, 1'b1, 2'd2, 4'd12);
        idle(2 * FRAME);

        for (int i = 0; i < 3000; i++) begin
            bit       e;
            bit       w;
            e = ($urandom_range(0, 39) != 0);
            w = ($urandom_range(0, 3) == 0);
            if (i == 1500) pulse_reset(1 + $urandom_range(0, 3));
            step(e, w, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        idle(4);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-shares the single seven-segment decoder across four common-anode digits.
- Holds four BCD digit values and scans them with a dead-time (blanking) gap between digits to prevent ghosting.
- Drives the decoder's 4-bit digit input and the active-low anode selector.
- Sits between the counter/control logic (which writes digit values) and the seven-segment decoder and display pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (blank plus show); frame = 4*REFRESH_DIV cycles.
- BLANK_CYCLES, 500: cycles per slot with all anodes off; legal range 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; low forces display dark.
- wr_en  in  1  digit write strobe, one cycle per write.
- wr_addr  in  2  digit index to write; 0 = least significant (rightmost), 3 = most significant.
- wr_data  in  4  BCD value; codes 10-15 are stored unchanged and blank via the decoder default.
- digit_out  out  4  value presented to the shared seven-segment decoder.
- an  out  4  active-low one-hot anode select.
- frame_start  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values (rst_n low, immediate):
  - an = 4'b1111, digit_out = 4'hF, frame_start = 0.
  - sel = 0, slot counter = 0, state = BLANK.
  - Shadow and active digit registers all 0.
- All outputs are registered and change only on clk edges, except for the asynchronous reset.
- Storage:
  - shadow[3:0]: written on any cycle with wr_en=1, shadow[wr_addr] <= wr_data.
  - active[3:0]: drives the display; loaded from shadow only at the commit point.
- FSM states:
  - BLANK: an = 1111, digit_out = F. Slot counter runs 0 .. BLANK_CYCLES-1, then moves to SHOW with the counter continuing.
  - SHOW: an = ~(1 << sel), digit_out = active[sel]. Counter runs to REFRESH_DIV-1, then resets to 0, sel <= sel+1 mod 4, state <= BLANK.
- Output timing: an and digit_out take their new values on the same edge as the state change, i.e. first visible in the cycle after the counter terminal value.
- Commit point is the SHOW(sel=3) -> BLANK(sel=0) transition:
  - active <= shadow, merging any write in that same cycle (a write on the commit edge is visible in the new frame).
  - frame_start = 1 for exactly that one following cycle.
  - No commit or frame_start occurs at reset release; the first frame displays 0000.
- en low:
  - Synchronously forces state BLANK, sel = 0, counter = 0, an = 1111, digit_out = F.
  - No commit; shadow writes are still accepted.
  - When en returns high, scanning restarts from the start of the BLANK slot for sel 0.
- Multiple writes to the same address within one frame: last write wins.
- Reset asserted mid-slot: everything returns to reset values; shadow contents are lost.
- The slot counter must be sized for REFRESH_DIV-1 and must never overflow.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, if sel != 0 and active[sel] and every active digit above sel are all 0, drive an = 1111 and digit_out = F for that slot. Timing is unchanged, and digit 0 is always shown.
- Undefined: all four digits are always shown, including leading zeros.

Test Plan (all with REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset then en=1, no writes -> first 2 cycles an=1111 and digit_out=F; next 6 cycles an=1110 and digit_out=0; sel steps 0,1,2,3 every 8 cycles; frame_start pulses first at cycle 32, then every 32 cycles.
- Write addr0=5, addr3=9 mid-frame -> display unchanged until the commit; next frame shows digit_out=5 in the an=1110 slot and 9 in the an=0111 slot.
- Write addr1=7 on the exact commit-edge cycle -> the new frame shows 7 in the an=1101 slot; writing addr1=4 on the following cycle is not visible until the next frame.
- Drop en for 3 cycles mid-SHOW of sel=2 -> an=1111 and digit_out=F while en is low; after re-enable, 2 BLANK cycles then an=1110; no frame_start is produced by the en toggle.
- Assert rst_n=0 asynchronously mid-SHOW -> an=1111, digit_out=F, frame_start=0 immediately; after release, the display shows 0000 regardless of earlier writes.
- With SEG_LEADING_ZERO_BLANK_EN and active={0,0,3,0} (digits 3..0) -> slots for sel 3 and 2 stay dark (an=1111); sel 1 shows 3; sel 0 shows 0.
